// File: rtl/axis_uart_tx_arbiter_pkg.sv
// Shared types and helpers for the UART transmit stream arbiter and its pick logic.
package axis_uart_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2
  } state_t;

  localparam logic [7:0] DEFAULT_HEADER_BASE = 8'hF0;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/axis_uart_tx_arbiter_rr_pick.sv
// Combinational round-robin pick: first requester after last_idx, wrapping, last_idx itself checked last.
module axis_uart_tx_arbiter_rr_pick #(
  parameter int NUM_CH = 4,
  parameter int IDX_W  = 2
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IDX_W-1:0]  last_idx,
  output logic [IDX_W-1:0]  next_idx,
  output logic              hit
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    hit      = 1'b0;
    next_idx = last_idx;
    cand     = last_idx;
    for (int i = 0; i < NUM_CH; i++) begin
      cand = (cand == IDX_W'(NUM_CH - 1)) ? '0 : cand + IDX_W'(1);
      if (!hit && req[cand]) begin
        hit      = 1'b1;
        next_idx = cand;
      end
    end
  end

endmodule

// File: rtl/axis_uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one UART transmit stream among NUM_CH sources,
// with optional channel-ID header and a per-grant beat cap.
module axis_uart_tx_arbiter
  import axis_uart_tx_arbiter_pkg::*;
#(
  parameter int         NUM_CH      = 4,
  parameter int         DATA_WIDTH  = 9,
  parameter int         HEADER_EN   = 1,
  parameter logic [7:0] HEADER_BASE = DEFAULT_HEADER_BASE,
  parameter int         MAX_BURST   = 64
) (
  input  logic                         aclk,
  input  logic                         areset,
  input  logic [NUM_CH*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_CH-1:0]            s_axis_tvalid,
  input  logic [NUM_CH-1:0]            s_axis_tlast,
  output logic [NUM_CH-1:0]            s_axis_tready,
  output logic [DATA_WIDTH-1:0]        m_axis_tdata,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic [clog2(NUM_CH)-1:0]     grant_ch,
  output logic                         busy,
  output logic                         burst_cut
);

  localparam int IDX_W = clog2(NUM_CH);
  localparam int CNT_W = (MAX_BURST == 0) ? 1 : clog2(MAX_BURST + 1);
  localparam logic [IDX_W-1:0] LAST_CH = IDX_W'(NUM_CH - 1);

  // Handshake: a beat moves on any edge where valid && ready; valid never waits on ready,
  // and a presented word (m_axis_tvalid high) holds data stable until accepted.

  state_t                 state, state_nx;
  logic [IDX_W-1:0]       grant_nx, pick_idx;
  logic                   pick_hit;
  logic [CNT_W-1:0]       beat_cnt, beat_cnt_nx, beat_cnt_inc;
  logic                   out_free, load, xfer;
  logic                   src_valid, src_last;
  logic [DATA_WIDTH-1:0]  src_data, hdr_word, load_data;

  axis_uart_tx_arbiter_rr_pick #(
    .NUM_CH (NUM_CH),
    .IDX_W  (IDX_W)
  ) u_rr_pick (
    .req      (s_axis_tvalid),
    .last_idx (grant_ch),
    .next_idx (pick_idx),
    .hit      (pick_hit)
  );

  always_comb begin
    src_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant_ch == IDX_W'(i)) src_data = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign src_valid    = s_axis_tvalid[grant_ch];
  assign src_last     = s_axis_tlast[grant_ch];
  assign out_free     = !m_axis_tvalid || m_axis_tready;
  assign xfer         = (state == DATA) && src_valid && out_free;
  assign beat_cnt_inc = beat_cnt + CNT_W'(1);
  assign hdr_word     = DATA_WIDTH'(HEADER_BASE) | DATA_WIDTH'(grant_ch);
  assign busy         = (state != IDLE);

  always_comb begin
    state_nx      = state;
    grant_nx      = grant_ch;
    beat_cnt_nx   = beat_cnt;
    load          = 1'b0;
    load_data     = src_data;
    s_axis_tready = '0;
    burst_cut     = 1'b0;
    case (state)
      IDLE: begin
        if (pick_hit) begin
          grant_nx = pick_idx;
          state_nx = (HEADER_EN != 0) ? HDR : DATA;
        end
      end
      HDR: begin
        if (out_free) begin
          load      = 1'b1;
          load_data = hdr_word;
          state_nx  = DATA;
        end
      end
      DATA: begin
        s_axis_tready[grant_ch] = out_free;
        if (xfer) begin
          load = 1'b1;
          // tlast wins over the cap when both land on the same beat
          if (src_last) begin
            state_nx    = IDLE;
            beat_cnt_nx = '0;
          end else if ((MAX_BURST != 0) && (beat_cnt_inc == CNT_W'(MAX_BURST))) begin
            burst_cut   = 1'b1;
            state_nx    = IDLE;
            beat_cnt_nx = '0;
          end else if (MAX_BURST != 0) begin
            beat_cnt_nx = beat_cnt_inc;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state         <= IDLE;
      grant_ch      <= LAST_CH;
      beat_cnt      <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
    end else begin
      state    <= state_nx;
      grant_ch <= grant_nx;
      beat_cnt <= beat_cnt_nx;
      if (out_free) begin
        m_axis_tvalid <= load;
        if (load) m_axis_tdata <= load_data;
      end
    end
  end

endmodule

// File: tb/tb_axis_uart_tx_arbiter.sv
// Directed bench: dut_a has headers and a 4-beat cap, dut_b has neither; scoreboards check output order.
`timescale 1ns/1ps
module tb_axis_uart_tx_arbiter;

  localparam int NCH = 4;
  localparam int DW  = 9;

  // clock / reset
  logic aclk = 1'b0;
  logic areset;
  int   cyc = 0;
  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;

  logic [NCH*DW-1:0] tdata_a, tdata_b;
  logic [NCH-1:0]    tvalid_a, tlast_a, tready_a, tvalid_b, tlast_b, tready_b;
  logic [DW-1:0]     mdata_a, mdata_b;
  logic              mvalid_a, mready_a, mvalid_b, mready_b;
  logic [1:0]        grant_a, grant_b;
  logic              busy_a, busy_b, cut_a, cut_b;

  axis_uart_tx_arbiter #(
    .NUM_CH(NCH), .DATA_WIDTH(DW), .HEADER_EN(1), .HEADER_BASE(8'hF0), .MAX_BURST(4)
  ) dut_a (
    .aclk(aclk), .areset(areset),
    .s_axis_tdata(tdata_a), .s_axis_tvalid(tvalid_a), .s_axis_tlast(tlast_a), .s_axis_tready(tready_a),
    .m_axis_tdata(mdata_a), .m_axis_tvalid(mvalid_a), .m_axis_tready(mready_a),
    .grant_ch(grant_a), .busy(busy_a), .burst_cut(cut_a)
  );

  axis_uart_tx_arbiter #(
    .NUM_CH(NCH), .DATA_WIDTH(DW), .HEADER_EN(0), .HEADER_BASE(8'hF0), .MAX_BURST(0)
  ) dut_b (
    .aclk(aclk), .areset(areset),
    .s_axis_tdata(tdata_b), .s_axis_tvalid(tvalid_b), .s_axis_tlast(tlast_b), .s_axis_tready(tready_b),
    .m_axis_tdata(mdata_b), .m_axis_tvalid(mvalid_b), .m_axis_tready(mready_b),
    .grant_ch(grant_b), .busy(busy_b), .burst_cut(cut_b)
  );

  // scoreboard state
  logic [DW-1:0] exp_a[$];
  logic [DW-1:0] exp_b[$];
  logic [DW:0]   src_a[NCH][$];
  logic [DW:0]   src_b[NCH][$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // driver: present queue heads, retire the beat that was accepted on the last edge
  logic [NCH-1:0] fire_a, fire_b;
  logic [DW:0]    head;
  initial begin
    tvalid_a = '0; tlast_a = '0; tdata_a = '0;
    tvalid_b = '0; tlast_b = '0; tdata_b = '0;
    forever begin
      @(negedge aclk);
      fire_a = tvalid_a & tready_a;
      fire_b = tvalid_b & tready_b;
      @(posedge aclk); #1;
      for (int c = 0; c < NCH; c++) begin
        if (fire_a[c] && src_a[c].size() > 0) void'(src_a[c].pop_front());
        if (fire_b[c] && src_b[c].size() > 0) void'(src_b[c].pop_front());
        if (src_a[c].size() > 0) begin
          head = src_a[c][0];
          tvalid_a[c] = 1'b1; tlast_a[c] = head[DW]; tdata_a[c*DW +: DW] = head[DW-1:0];
        end else begin
          tvalid_a[c] = 1'b0; tlast_a[c] = 1'b0;
        end
        if (src_b[c].size() > 0) begin
          head = src_b[c][0];
          tvalid_b[c] = 1'b1; tlast_b[c] = head[DW]; tdata_b[c*DW +: DW] = head[DW-1:0];
        end else begin
          tvalid_b[c] = 1'b0; tlast_b[c] = 1'b0;
        end
      end
    end
  end

  task automatic push_pkt_a(input int ch, input int n, input logic [DW-1:0] base);
    for (int i = 0; i < n; i++) src_a[ch].push_back({(i == n - 1), base + DW'(i)});
  endtask

  task automatic exp_seg_a(input int ch, input logic [DW-1:0] base, input int first, input int n);
    exp_a.push_back(9'h0F0 | DW'(ch));
    for (int i = 0; i < n; i++) exp_a.push_back(base + DW'(first + i));
  endtask

  // monitor A
  logic          gap_on = 1'b0, gap_first = 1'b1, prev_stall_a = 1'b0;
  logic [DW-1:0] prev_data_a, word_a, cut_word_a;
  int            prev_cyc_a = 0, cut_cnt_a = 0;
  initial forever begin
    @(negedge aclk);
    if (areset) begin
      prev_stall_a = 1'b0;
    end else begin
      chk("tready_onehot0_a", {31'd0, $onehot0(tready_a)}, 32'd1);
      if (prev_stall_a) chk("stall_hold_a", {22'd0, mvalid_a, mdata_a}, {22'd1, prev_data_a});
      if (mvalid_a && !mready_a) chk("tready_low_when_full_a", {28'd0, tready_a}, 32'd0);
      if (cut_a) begin
        cut_cnt_a++;
        cut_word_a = tdata_a[int'(grant_a)*DW +: DW];
      end
      if (mvalid_a && mready_a) begin
        if (exp_a.size() == 0) begin
          chk("unexpected_word_a", {23'd0, mdata_a}, 32'h1FF_FFFF);
        end else begin
          word_a = exp_a.pop_front();
          chk("data_a", {23'd0, mdata_a}, {23'd0, word_a});
          if (gap_on) begin
            if (!gap_first)
              chk("beat_spacing_a", cyc - prev_cyc_a, ((word_a & 9'h1F0) == 9'h0F0) ? 2 : 1);
            gap_first  = 1'b0;
            prev_cyc_a = cyc;
          end
        end
      end
      prev_stall_a = mvalid_a && !mready_a;
      prev_data_a  = mdata_a;
    end
  end

  // monitor B
  logic          first_b = 1'b1;
  logic [DW-1:0] word_b;
  int            first_cyc_b = 0, last_cyc_b = 0, cut_cnt_b = 0;
  initial forever begin
    @(negedge aclk);
    if (!areset) begin
      if (cut_b) cut_cnt_b++;
      if (mvalid_b && mready_b) begin
        if (exp_b.size() == 0) begin
          chk("unexpected_word_b", {23'd0, mdata_b}, 32'h1FF_FFFF);
        end else begin
          word_b = exp_b.pop_front();
          chk("data_b", {23'd0, mdata_b}, {23'd0, word_b});
          if (first_b) first_cyc_b = cyc;
          first_b    = 1'b0;
          last_cyc_b = cyc;
        end
      end
    end
  end

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while ((exp_a.size() != 0 || exp_b.size() != 0) && n < budget) begin
      @(posedge aclk);
      n++;
    end
    if (n >= budget) begin
      chk(name, exp_a.size() + exp_b.size(), 0);
      exp_a.delete();
      exp_b.delete();
    end
    @(negedge aclk); #2;
  endtask

  logic tog_on = 1'b0;
  initial forever begin
    @(posedge aclk); #1;
    if (tog_on) mready_a = ~mready_a;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    areset = 1'b1; mready_a = 1'b1; mready_b = 1'b1;
    repeat (3) @(negedge aclk);
    chk("reset_grant_a", {30'd0, grant_a}, 32'd3);
    chk("reset_out_a", {22'd0, mvalid_a, mdata_a}, 32'd0);
    chk("reset_ctrl_a", {26'd0, busy_a, cut_a, tready_a}, 32'd0);
    chk("reset_grant_b", {30'd0, grant_b}, 32'd3);
    areset = 1'b0;

    // round-robin fairness: every channel holds two 2-beat packets
    @(negedge aclk); #1;
    gap_on = 1'b1; gap_first = 1'b1;
    for (int p = 0; p < 2; p++)
      for (int c = 0; c < NCH; c++) push_pkt_a(c, 2, DW'(32 * c + 4 * p));
    for (int p = 0; p < 2; p++)
      for (int c = 0; c < NCH; c++) exp_seg_a(c, DW'(32 * c + 4 * p), 0, 2);
    drain("fairness_drain", 200);
    chk("fairness_no_cut", cut_cnt_a, 0);

    // single packet from ch2
    gap_first = 1'b1;
    push_pkt_a(2, 3, 9'h041);
    exp_seg_a(2, 9'h041, 0, 3);
    drain("single_drain", 100);
    chk("single_grant", {30'd0, grant_a}, 32'd2);
    chk("single_busy_low", {31'd0, busy_a}, 32'd0);

    // burst cut: ch1 sends 6 beats, ch2 joins once ch1 holds the grant
    gap_first = 1'b1; cut_cnt_a = 0;
    push_pkt_a(1, 6, 9'h080);
    exp_seg_a(1, 9'h080, 0, 4);
    exp_seg_a(2, 9'h090, 0, 1);
    exp_seg_a(1, 9'h080, 4, 2);
    n = 0;
    while (!(busy_a && grant_a == 2'd1) && n < 50) begin @(negedge aclk); n++; end
    chk("burst_grant_seen", {31'd0, n < 50}, 32'd1);
    #1 push_pkt_a(2, 1, 9'h090);
    drain("burst_drain", 200);
    chk("burst_cut_count", cut_cnt_a, 1);
    chk("burst_cut_beat", {23'd0, cut_word_a}, 32'h083);
    gap_on = 1'b0;

    // backpressure: ready toggles every cycle over an 8-beat packet
    cut_cnt_a = 0;
    tog_on = 1'b1;
    push_pkt_a(3, 8, 9'h0A0);
    exp_seg_a(3, 9'h0A0, 0, 4);
    exp_seg_a(3, 9'h0A0, 4, 4);
    drain("backpressure_drain", 300);
    tog_on = 1'b0; mready_a = 1'b1;
    chk("backpressure_cut_count", cut_cnt_a, 1);

    // async reset in the middle of a 5-beat packet
    push_pkt_a(2, 5, 9'h0B0);
    exp_seg_a(2, 9'h0B0, 0, 5);
    n = 0;
    while (exp_a.size() > 3 && n < 100) begin @(posedge aclk); n++; end
    chk("reset_mid_reached", {31'd0, n < 100}, 32'd1);
    @(posedge aclk); #3;
    areset = 1'b1;
    for (int c = 0; c < NCH; c++) src_a[c].delete();
    tvalid_a = '0;
    exp_a.delete();
    #1;
    chk("reset_mid_mvalid", {31'd0, mvalid_a}, 32'd0);
    chk("reset_mid_tready", {28'd0, tready_a}, 32'd0);
    chk("reset_mid_grant", {29'd0, busy_a, grant_a}, 32'd3);
    @(negedge aclk);
    @(posedge aclk); #3;
    areset = 1'b0;
    @(negedge aclk); #1;
    push_pkt_a(2, 1, 9'h0C2);
    push_pkt_a(0, 1, 9'h0C0);
    exp_seg_a(0, 9'h0C0, 0, 1);
    exp_seg_a(2, 9'h0C2, 0, 1);
    drain("post_reset_drain", 100);
    chk("post_reset_grant", {30'd0, grant_a}, 32'd2);

    // no header, no cap: one 200-beat packet from ch3 on dut_b
    for (int i = 0; i < 200; i++) begin
      src_b[3].push_back({(i == 199), DW'(i)});
      exp_b.push_back(DW'(i));
    end
    drain("long_drain", 600);
    chk("long_no_cut", cut_cnt_b, 0);
    chk("long_span", last_cyc_b - first_cyc_b, 199);
    chk("long_grant_idle", {29'd0, busy_b, grant_b}, 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axis_uart_tx_arbiter.md
Name: axis_uart_tx_arbiter

Overview:
- Round-robin, packet-granular arbiter that shares one UART transmit AXI-Stream slave among NUM_CH requesters.
- Optionally prefixes each granted packet with a channel-ID header word.
- Caps packet length at MAX_BURST beats so no requester can hog the link.
- Sits directly in front of the UART core's s_axis_tdata/tvalid/tready port; output is registered.

Parameters:
- NUM_CH, 4, number of requester channels (2..8).
- DATA_WIDTH, 9, tdata width per channel and at output; matches the UART 9-bit stream.
- HEADER_EN, 1, 1 = emit a header word before each grant; 0 = no header.
- HEADER_BASE, 8'hF0, header word = HEADER_BASE OR channel index, zero-extended to DATA_WIDTH.
- MAX_BURST, 64, maximum data beats per grant; 0 = unlimited (release only on tlast).

Ports:
- aclk  in  1  clock.
- areset  in  1  asynchronous, active-high reset.
- s_axis_tdata  in  NUM_CH*DATA_WIDTH  channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- s_axis_tvalid  in  NUM_CH  per-channel valid.
- s_axis_tlast  in  NUM_CH  per-channel end of packet.
- s_axis_tready  out  NUM_CH  per-channel ready; at most one bit high.
- m_axis_tdata  out  DATA_WIDTH  to the UART core.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  UART core ready.
- grant_ch  out  clog2(NUM_CH)  index of the current or last granted channel.
- busy  out  1  high while state is not IDLE.
- burst_cut  out  1  one-cycle pulse when a grant is released by MAX_BURST without tlast.

Behaviour:
- Reset (async, areset=1): state=IDLE; m_axis_tvalid=0; m_axis_tdata=0; s_axis_tready=0; grant_ch=NUM_CH-1 (so channel 0 is served first); beat count=0; busy=0; burst_cut=0.
- Reset asserted mid-packet drops the in-flight beat silently; there is no recovery framing.
- Output register: single stage. It is free when !m_axis_tvalid || m_axis_tready. It loads on any cycle it is free and a word is available. m_axis_tvalid and m_axis_tdata hold stable while m_axis_tvalid && !m_axis_tready.
- State IDLE:
  - Search channels starting at (grant_ch+1) mod NUM_CH, wrapping; pick the first with tvalid=1.
  - If none is found, stay in IDLE.
  - On a hit: register grant_ch; go to HDR if HEADER_EN, else DATA. Arbitration takes 1 cycle.
- State HDR:
  - When the output register is free, load the header word and go to DATA.
  - No s_axis_tready is asserted in HDR.
- State DATA:
  - s_axis_tready[grant_ch] = output register free; all other tready bits = 0.
  - A source beat transfers when tvalid&&tready. It lands on m_axis the next cycle (latency 1).
  - Each transfer increments the beat count.
  - Transfer with tlast=1: go to IDLE, clear the count.
  - Transfer with count+1 == MAX_BURST and tlast=0 (MAX_BURST != 0): pulse burst_cut for that cycle, go to IDLE, clear the count.
  - The cut channel keeps its pending data. It re-arbitrates last in rotation order and gets a fresh header.
  - A tlast beat that also reaches MAX_BURST counts as tlast; no burst_cut.
- Back-to-back: IDLE to grant costs one bubble cycle between packets. Sustained throughput inside a packet is 1 beat/cycle when m_axis_tready=1.
- A requester that drops tvalid mid-packet keeps its grant; no timeout.
- Beat counter width is clog2(MAX_BURST+1); it never wraps, because it clears at the limit.
- tlast is not forwarded; the UART has no framing.

Decomposition:
- Shared package holds:
  - state enum (IDLE, HDR, DATA);
  - default HEADER_BASE constant;
  - a clog2 function.
- One natural sub-module: rr_pick. It is combinational: it takes the request vector and the last grant index and returns the next index plus a hit flag. It is reusable by other shared-UART controllers.
- The output register stays inline.

Test Plan:
- Single packet: ch2 sends 3 beats 0x041,0x042,0x043(tlast), m_axis_tready=1, HEADER_EN=1 -> m_axis shows 0x0F2,0x041,0x042,0x043 on consecutive cycles; grant_ch=2; busy drops after the last beat.
- Round-robin fairness: all 4 channels hold 2-beat packets continuously -> header order F0,F1,F2,F3,F0…; each grant is separated by exactly one idle cycle.
- Burst cut: MAX_BURST=4, ch1 sends 6 beats with tlast on the 6th -> F1+4 beats, burst_cut pulses on the 4th beat, other channels are served if pending, then F1+2 beats.
- Backpressure: m_axis_tready toggled 0/1 every cycle during an 8-beat packet -> no beat lost or duplicated; m_axis_tdata stable while stalled; s_axis_tready[g] low whenever the output register is full and not draining.
- Async reset mid-packet: areset pulsed during beat 3 of 5 -> m_axis_tvalid=0 and s_axis_tready=0 immediately; next grant goes to ch0.
- HEADER_EN=0, MAX_BURST=0: 200-beat packet from ch3 -> exactly 200 beats forwarded, no header, no burst_cut.
